// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller (credit, select, dispense, change, refund).
// Define VEND_STOCK_EN to add per-product stock counters, restock input and err_sold_out pulse.
module vend_ctrl_param #(
  parameter int N_PROD     = 4,
  parameter int SEL_W      = 3,
  parameter int CREDIT_W   = 7,
  parameter int PRICE_BASE = 10,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 99
`ifdef VEND_STOCK_EN
  ,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
`ifdef VEND_STOCK_EN
  input  logic                restock,
  output logic                err_sold_out,
`endif
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   avail,
  output logic                busy,
  output logic                dispense_valid,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                err_invalid,
  output logic                err_insuff
);
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, amt_n;
  logic [SEL_W-1:0] id_n;
  logic [CREDIT_W:0] sum, rem, sel_price;
  logic disp_n, chg_n, in_range, sold_out, do_cancel, do_sel, open, coin_ok, sel_ok;

  function automatic logic [CREDIT_W:0] price(input int i);
    return (CREDIT_W+1)'(PRICE_BASE + (i - 1) * PRICE_STEP);
  endfunction

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [N_PROD];
  always_comb begin
    sold_out = 1'b0;
    for (int i = 0; i < N_PROD; i++)
      sold_out = sold_out | (sel == SEL_W'(i + 1) && stock[i] == '0);
  end
  // restock wins over the decrement issued while leaving VEND
  always_ff @(posedge clk)
    for (int i = 0; i < N_PROD; i++)
      stock[i] <= (reset || restock) ? STOCK_W'(STOCK_INIT) :
                  (state == VEND && dispense_id == SEL_W'(i + 1)) ? stock[i] - STOCK_W'(1) : stock[i];
  always_ff @(posedge clk)
    err_sold_out <= !reset && do_sel && in_range && sold_out;
  for (genvar g = 0; g < N_PROD; g++) begin : g_avail
    assign avail[g] = {1'b0, credit} >= price(g + 1) && stock[g] != '0;
  end
`else
  assign sold_out = 1'b0;
  for (genvar g = 0; g < N_PROD; g++) begin : g_avail
    assign avail[g] = {1'b0, credit} >= price(g + 1);
  end
`endif

  always_comb begin
    sum       = {1'b0, credit} + {1'b0, coin_val};
    rem       = {1'b0, credit} - price(int'(dispense_id));
    sel_price = price(int'(sel));
    in_range  = sel != '0 && int'(sel) <= N_PROD;
    do_cancel = state == CREDIT && cancel;
    do_sel    = state == CREDIT && sel_valid && !cancel;
    open      = (state == IDLE || state == CREDIT) && !do_cancel && !do_sel;
    coin_ok   = coin_valid && coin_val != '0 && open && sum <= (CREDIT_W+1)'(MAX_CREDIT);
    sel_ok    = do_sel && in_range && !sold_out && sel_price <= {1'b0, credit};
    state_n   = state;
    credit_n  = credit;
    disp_n    = 1'b0;
    id_n      = '0;
    chg_n     = 1'b0;
    amt_n     = '0;
    case (state)
      IDLE, CREDIT:
        if (do_cancel) begin
          state_n = CHANGE;
          chg_n   = 1'b1;
          amt_n   = credit;
        end else if (sel_ok) begin
          state_n = VEND;
          disp_n  = 1'b1;
          id_n    = sel;
        end else if (coin_ok) begin
          state_n  = CREDIT;
          credit_n = sum[CREDIT_W-1:0];
        end
      VEND: begin
        credit_n = rem[CREDIT_W-1:0];
        state_n  = rem != '0 ? CHANGE : IDLE;
        chg_n    = rem != '0;
        amt_n    = rem[CREDIT_W-1:0];
      end
      default: begin
        credit_n = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      credit         <= '0;
      busy           <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= '0;
      change_valid   <= 1'b0;
      change_amt     <= '0;
      coin_reject    <= 1'b0;
      err_invalid    <= 1'b0;
      err_insuff     <= 1'b0;
    end else begin
      state          <= state_n;
      credit         <= credit_n;
      busy           <= state_n == VEND || state_n == CHANGE;
      dispense_valid <= disp_n;
      dispense_id    <= id_n;
      change_valid   <= chg_n;
      change_amt     <= amt_n;
      coin_reject    <= coin_valid && coin_val != '0 && !coin_ok;
      err_invalid    <= do_sel && !in_range;
      err_insuff     <= do_sel && in_range && !sold_out && sel_price > {1'b0, credit};
    end
  end
endmodule
